// File: rtl/tile_sequencer_if.sv
// Handshake/status bundle between the top-level controller and tile_sequencer.
// Latency: none (wires only).
// Backpressure: stall_i from the controller freezes the sequencer schedule.
// Ports: start_i/stall_i are driven by the controller (master); all *_o signals
// are driven by the sequencer (slave). Widths follow the array parameters.
interface tile_sequencer_if #(
    parameter int PE_SIZE        = 14,
    parameter int WEIGHT_ROW_NUM = 70,
    parameter int WEIGHT_COL_NUM = 294,
    parameter int FLUSH_PASSES   = 3
);
    localparam int NUM_TILES    = (WEIGHT_COL_NUM + PE_SIZE - 1) / PE_SIZE;
    localparam int TOTAL_PASSES = NUM_TILES + FLUSH_PASSES;
    localparam int PRE_W  = (PE_SIZE > 1)        ? $clog2(PE_SIZE)        : 1;
    localparam int ROW_W  = (WEIGHT_ROW_NUM > 1) ? $clog2(WEIGHT_ROW_NUM) : 1;
    localparam int PASS_W = (TOTAL_PASSES > 1)   ? $clog2(TOTAL_PASSES)   : 1;

    logic              start_i;
    logic              stall_i;
    logic              busy_o;
    logic              preload_en_o;
    logic [PRE_W-1:0]  preload_idx_o;
    logic              psum_en_o;
    logic [ROW_W-1:0]  weight_row_o;
    logic [PASS_W-1:0] pass_idx_o;
    logic              flush_o;
    logic              done_o;

    modport master (
        output start_i, stall_i,
        input  busy_o, preload_en_o, preload_idx_o, psum_en_o,
               weight_row_o, pass_idx_o, flush_o, done_o
    );

    modport slave (
        input  start_i, stall_i,
        output busy_o, preload_en_o, preload_idx_o, psum_en_o,
               weight_row_o, pass_idx_o, flush_o, done_o
    );
endinterface

// File: rtl/tile_sequencer.sv
// Compute-schedule sequencer: per pass, PE_SIZE preload cycles then WEIGHT_ROW_NUM psum_en cycles.
// Latency: preload_en_o first high the cycle after start_i is sampled; done_o one cycle after last pass.
// Backpressure: stall_i freezes state and counters; enables are gated combinationally by stall_i.
// Ports: clk, rst (sync, active-high), bus (tile_sequencer_if.slave): start_i/stall_i in;
// busy_o, preload_en_o, preload_idx_o, psum_en_o, weight_row_o, pass_idx_o, flush_o, done_o out.
module tile_sequencer #(
    parameter int PE_SIZE        = 14,
    parameter int WEIGHT_ROW_NUM = 70,
    parameter int WEIGHT_COL_NUM = 294,
    parameter int FLUSH_PASSES   = 3
) (
    input  logic               clk,
    input  logic               rst,
    tile_sequencer_if.slave    bus
);
    localparam int NUM_TILES    = (WEIGHT_COL_NUM + PE_SIZE - 1) / PE_SIZE;
    localparam int TOTAL_PASSES = NUM_TILES + FLUSH_PASSES;
    localparam int PRE_W  = (PE_SIZE > 1)        ? $clog2(PE_SIZE)        : 1;
    localparam int ROW_W  = (WEIGHT_ROW_NUM > 1) ? $clog2(WEIGHT_ROW_NUM) : 1;
    localparam int PASS_W = (TOTAL_PASSES > 1)   ? $clog2(TOTAL_PASSES)   : 1;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_PRELOAD = 2'd1;
    localparam logic [1:0] S_STREAM  = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(PE_SIZE - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(WEIGHT_ROW_NUM - 1);
    localparam logic [PASS_W-1:0] PASS_LAST = PASS_W'(TOTAL_PASSES - 1);
    // One extra bit so NUM_TILES still compares correctly when there are no flush passes.
    localparam logic [PASS_W:0]   FLUSH_FROM = (PASS_W + 1)'(NUM_TILES);

    logic [1:0]        state_q, state_d;
    logic [PRE_W-1:0]  pre_q,   pre_d;
    logic [ROW_W-1:0]  row_q,   row_d;
    logic [PASS_W-1:0] pass_q,  pass_d;

    always_comb begin
        state_d = state_q;
        pre_d   = pre_q;
        row_d   = row_q;
        pass_d  = pass_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start_i) begin
                    state_d = S_PRELOAD;
                    pre_d   = '0;
                    row_d   = '0;
                    pass_d  = '0;
                end
            end
            S_PRELOAD: begin
                if (!bus.stall_i) begin
                    if (pre_q == PRE_LAST) begin
                        state_d = S_STREAM;
                        row_d   = '0;
                    end else begin
                        pre_d = pre_q + PRE_W'(1);
                    end
                end
            end
            S_STREAM: begin
                if (!bus.stall_i) begin
                    if (row_q == ROW_LAST) begin
                        // Next pass starts immediately: no bubble between bursts.
                        if (pass_q < PASS_LAST) begin
                            state_d = S_PRELOAD;
                            pass_d  = pass_q + PASS_W'(1);
                            pre_d   = '0;
                        end else begin
                            state_d = S_DONE;
                        end
                    end else begin
                        row_d = row_q + ROW_W'(1);
                    end
                end
            end
            S_DONE: begin
                // Return to a clean idle so the register outputs read zero between runs.
                state_d = S_IDLE;
                pre_d   = '0;
                row_d   = '0;
                pass_d  = '0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            pre_q   <= '0;
            row_q   <= '0;
            pass_q  <= '0;
        end else begin
            state_q <= state_d;
            pre_q   <= pre_d;
            row_q   <= row_d;
            pass_q  <= pass_d;
        end
    end

    assign bus.busy_o        = (state_q != S_IDLE);
    assign bus.preload_en_o  = (state_q == S_PRELOAD) & ~bus.stall_i;
    assign bus.psum_en_o     = (state_q == S_STREAM) & ~bus.stall_i;
    assign bus.done_o        = (state_q == S_DONE);
    assign bus.flush_o       = bus.busy_o & ({1'b0, pass_q} >= FLUSH_FROM);
    assign bus.preload_idx_o = pre_q;
    assign bus.weight_row_o  = row_q;
    assign bus.pass_idx_o    = pass_q;
endmodule

// File: tb/tb_tile_sequencer.sv
// Bench for tile_sequencer: default-parameter instance plus a small-parameter instance.
// Expected per-cycle enable/index/pass/flush records are queued at start and popped as the DUT strobes.
module tb_tile_sequencer;
    // Default instance schedule constants
    localparam int D_PE = 14, D_ROWS = 70, D_TILES = 21, D_PASSES = 24;
    // Small instance: ceil(10/4) = 3 tiles + 1 flush pass
    localparam int S_PE = 4, S_ROWS = 3, S_TILES = 3, S_PASSES = 4;

    typedef logic [34:0] vec_t;

    logic clk;
    logic rst;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    vec_t q0[$];
    vec_t q1[$];
    int   start_edge[2];
    int   exp_done[2];
    int   dones[2];
    int   pops[2];
    bit   armed[2];

    tile_sequencer_if #(.PE_SIZE(14), .WEIGHT_ROW_NUM(70), .WEIGHT_COL_NUM(294), .FLUSH_PASSES(3)) bus0 ();
    tile_sequencer_if #(.PE_SIZE(4),  .WEIGHT_ROW_NUM(3),  .WEIGHT_COL_NUM(10),  .FLUSH_PASSES(1)) bus1 ();

    tile_sequencer #(.PE_SIZE(14), .WEIGHT_ROW_NUM(70), .WEIGHT_COL_NUM(294), .FLUSH_PASSES(3)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0)
    );
    tile_sequencer #(.PE_SIZE(4), .WEIGHT_ROW_NUM(3), .WEIGHT_COL_NUM(10), .FLUSH_PASSES(1)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1)
    );

    logic [31:0] outs0, outs1;
    assign outs0 = 32'({bus0.busy_o, bus0.preload_en_o, bus0.psum_en_o, bus0.done_o, bus0.flush_o,
                        bus0.preload_idx_o, bus0.weight_row_o, bus0.pass_idx_o});
    assign outs1 = 32'({bus1.busy_o, bus1.preload_en_o, bus1.psum_en_o, bus1.done_o, bus1.flush_o,
                        bus1.preload_idx_o, bus1.weight_row_o, bus1.pass_idx_o});

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic vec_t pack(input logic pe, input logic ps, input int idx, input int pass, input logic fl);
        return {pe, ps, idx[15:0], pass[15:0], fl};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Per-cycle observer for one instance; only runs while a schedule is armed.
    task automatic mon(input int d, input logic pe, input logic ps, input int pidx, input int row,
                       input int pass, input logic fl, input logic dn, input logic bsy);
        vec_t e;
        int   rel;
        if (!armed[d]) return;
        rel = cyc - start_edge[d] + 1;
        if (pe || ps) begin
            e = '0;
            if (d == 0 && q0.size() > 0) e = q0.pop_front();
            else if (d == 1 && q1.size() > 0) e = q1.pop_front();
            if (pops[d] == 0) chk(d == 0 ? "first_pre_cyc0" : "first_pre_cyc1", rel, 1);
            pops[d]++;
            chk(d == 0 ? "sched0" : "sched1", pack(pe, ps, pe ? pidx : row, pass, fl), e);
        end
        if (dn) begin
            dones[d]++;
            chk(d == 0 ? "done_cyc0" : "done_cyc1", rel, exp_done[d]);
        end
        if (rel == exp_done[d] + 1) begin
            chk(d == 0 ? "busy_fall0" : "busy_fall1", bsy, 0);
            armed[d] = 0;
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            mon(0, bus0.preload_en_o, bus0.psum_en_o, int'(bus0.preload_idx_o), int'(bus0.weight_row_o),
                int'(bus0.pass_idx_o), bus0.flush_o, bus0.done_o, bus0.busy_o);
            mon(1, bus1.preload_en_o, bus1.psum_en_o, int'(bus1.preload_idx_o), int'(bus1.weight_row_o),
                int'(bus1.pass_idx_o), bus1.flush_o, bus1.done_o, bus1.busy_o);
        end
    end

    // Pulse start for one cycle and push the full expected schedule.
    task automatic run_start(input int d);
        int pe, rows, nt, np;
        if (d == 0) begin
            pe = D_PE; rows = D_ROWS; nt = D_TILES; np = D_PASSES;
            bus0.start_i = 1'b1;
        end else begin
            pe = S_PE; rows = S_ROWS; nt = S_TILES; np = S_PASSES;
            bus1.start_i = 1'b1;
        end
        start_edge[d] = cyc + 1;
        exp_done[d]   = 1 + np * (pe + rows);
        dones[d]      = 0;
        pops[d]       = 0;
        for (int p = 0; p < np; p++) begin
            for (int i = 0; i < pe; i++) begin
                if (d == 0) q0.push_back(pack(1'b1, 1'b0, i, p, p >= nt));
                else        q1.push_back(pack(1'b1, 1'b0, i, p, p >= nt));
            end
            for (int r = 0; r < rows; r++) begin
                if (d == 0) q0.push_back(pack(1'b0, 1'b1, r, p, p >= nt));
                else        q1.push_back(pack(1'b0, 1'b1, r, p, p >= nt));
            end
        end
        armed[d] = 1;
        tick();
        bus0.start_i = 1'b0;
        bus1.start_i = 1'b0;
    endtask

    task automatic wait_idle(input int d, input int budget);
        for (int i = 0; i < budget && armed[d]; i++) tick();
        chk(d == 0 ? "timeout0" : "timeout1", armed[d], 0);
    endtask

    task automatic end_run(input int d, input string tag);
        chk({tag, "_dones"}, dones[d], 1);
        chk({tag, "_sb_left"}, d == 0 ? q0.size() : q1.size(), 0);
    endtask

    initial begin
        rst = 1'b1;
        bus0.start_i = 1'b1; bus0.stall_i = 1'b0;
        bus1.start_i = 1'b1; bus1.stall_i = 1'b0;
        armed[0] = 0; armed[1] = 0;

        // Reset held with start_i high: must stay idle with all outputs zero.
        repeat (2) begin
            tick();
            chk("rst_idle0", outs0, 0);
            chk("rst_idle1", outs1, 0);
        end
        rst = 1'b0;
        bus0.start_i = 1'b0;
        bus1.start_i = 1'b0;
        tick();
        chk("post_rst_idle0", outs0, 0);
        chk("post_rst_idle1", outs1, 0);

        // Small parameters: 4 passes of 4+3, flush only in pass 3, done at start+29.
        run_start(1);
        wait_idle(1, 100);
        end_run(1, "small");

        // Full default run with a start_i pulse while busy at pass 5.
        run_start(0);
        for (int i = 0; i < 1000; i++) begin
            if (bus0.pass_idx_o == 5) break;
            tick();
        end
        chk("reach_pass5", bus0.pass_idx_o, 5);
        bus0.start_i = 1'b1;
        tick();
        bus0.start_i = 1'b0;
        wait_idle(0, 3000);
        end_run(0, "full");

        // Stall 5 cycles at row 30 of pass 2.
        run_start(0);
        for (int i = 0; i < 1000; i++) begin
            if (bus0.pass_idx_o == 2 && bus0.weight_row_o == 30 && bus0.psum_en_o) break;
            tick();
        end
        chk("reach_row30", bus0.weight_row_o, 30);
        for (int i = 0; i < 5; i++) begin
            bus0.stall_i = 1'b1;
            #1;
            chk("stall_psum", bus0.psum_en_o, 0);
            chk("stall_row", bus0.weight_row_o, 30);
            exp_done[0]++;
            tick();
        end
        bus0.stall_i = 1'b0;
        chk("stall_done_shift", exp_done[0], 2022);
        wait_idle(0, 3000);
        end_run(0, "stall");

        // Reset during STREAM of pass 10, then a clean restart.
        run_start(0);
        for (int i = 0; i < 2000; i++) begin
            if (bus0.pass_idx_o == 10 && bus0.psum_en_o) break;
            tick();
        end
        chk("reach_pass10", bus0.pass_idx_o, 10);
        rst = 1'b1;
        tick();
        chk("rst_mid_idle", outs0, 0);
        q0.delete();
        armed[0] = 0;
        rst = 1'b0;
        tick();
        chk("rst_mid_stay_idle", outs0, 0);
        run_start(0);
        wait_idle(0, 3000);
        end_run(0, "restart");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
